// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg -- fetch/decode pipeline register with fetch-address checking and
// performance counters.
//
// Captures the fetched instruction word and its address into the decode slot.
// A misaligned or out-of-window fetch address is turned into an AdEL fetch
// exception. The fetched word is replaced by a zero word (nop) so decode never
// acts on it.
//
// Parameters:
//   PC_BASE   lowest legal fetch address; also the reset value of pc_D
//   PC_LIMIT  highest legal fetch address
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous active-high reset
//   Instr        in   32  instruction word from fetch
//   pc           in   32  address of Instr
//   InDelaySlot  in   1   fetched word sits in a branch/jump delay slot
//   Stall        in   1   hold the decode slot
//   Flush        in   1   insert a bubble (wins over Stall)
//   Instr_D      out  32  registered instruction
//   pc_D         out  32  registered instruction address
//   pc8_D        out  32  registered link address pc+8
//   Valid_D      out  1   decode slot holds a real fetched instruction
//   BD_D         out  1   registered delay-slot flag
//   ExcCode_D    out  5   fetch exception code (0 none, 4 AdEL)
//   FetchCnt     out  32  saturating count of load edges
//   StallCnt     out  32  saturating count of stalled edges
// -----------------------------------------------------------------------------
module if_id_reg #(
  parameter logic [31:0] PC_BASE  = 32'h0000_3000,
  parameter logic [31:0] PC_LIMIT = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [31:0] pc,
  input  logic        InDelaySlot,
  input  logic        Stall,
  input  logic        Flush,
  output logic [31:0] Instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        Valid_D,
  output logic        BD_D,
  output logic [4:0]  ExcCode_D,
  output logic [31:0] FetchCnt,
  output logic [31:0] StallCnt
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_instr_p0;
  logic [31:0] r_pc_p0;
  logic [31:0] r_pc8_p0;
  logic        r_vld_p0;
  logic        r_bd_p0;
  logic [4:0]  r_exc_p0;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  logic        w_fault;
  logic [31:0] w_pc8;

  // Unsigned window compare plus word alignment.
  assign w_fault = (pc[1:0] != 2'b00) || (pc < PC_BASE) || (pc > PC_LIMIT);
  assign w_pc8   = pc + 32'd8;

  // ---- fetch -> decode boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_p0  <= 32'h0000_0000;
      r_pc_p0     <= PC_BASE;
      r_pc8_p0    <= PC_BASE + 32'd8;
      r_vld_p0    <= 1'b0;
      r_bd_p0     <= 1'b0;
      r_exc_p0    <= EXC_NONE;
      r_fetch_cnt <= 32'h0000_0000;
      r_stall_cnt <= 32'h0000_0000;
    end else if (Flush) begin
      // Bubble still tracks the current pc so exception reporting has an address.
      r_instr_p0 <= 32'h0000_0000;
      r_pc_p0    <= pc;
      r_pc8_p0   <= w_pc8;
      r_vld_p0   <= 1'b0;
      r_bd_p0    <= 1'b0;
      r_exc_p0   <= EXC_NONE;
    end else if (Stall) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end else begin
      r_instr_p0  <= w_fault ? 32'h0000_0000 : Instr;
      r_pc_p0     <= pc;
      r_pc8_p0    <= w_pc8;
      r_vld_p0    <= 1'b1;
      r_bd_p0     <= InDelaySlot;
      r_exc_p0    <= w_fault ? EXC_ADEL : EXC_NONE;
      r_fetch_cnt <= sat_inc(r_fetch_cnt);
    end
  end

  assign Instr_D   = r_instr_p0;
  assign pc_D      = r_pc_p0;
  assign pc8_D     = r_pc8_p0;
  assign Valid_D   = r_vld_p0;
  assign BD_D      = r_bd_p0;
  assign ExcCode_D = r_exc_p0;
  assign FetchCnt  = r_fetch_cnt;
  assign StallCnt  = r_stall_cnt;

endmodule

// File: tb/tb_if_id_reg.sv
module tb_if_id_reg;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [31:0] pc;
  logic        InDelaySlot;
  logic        Stall;
  logic        Flush;
  logic [31:0] Instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;
  logic        Valid_D;
  logic        BD_D;
  logic [4:0]  ExcCode_D;
  logic [31:0] FetchCnt;
  logic [31:0] StallCnt;

  if_id_reg dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .pc         (pc),
    .InDelaySlot(InDelaySlot),
    .Stall      (Stall),
    .Flush      (Flush),
    .Instr_D    (Instr_D),
    .pc_D       (pc_D),
    .pc8_D      (pc8_D),
    .Valid_D    (Valid_D),
    .BD_D       (BD_D),
    .ExcCode_D  (ExcCode_D),
    .FetchCnt   (FetchCnt),
    .StallCnt   (StallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcv;
    logic [31:0] pc8;
    logic        vld;
    logic        bd;
    logic [4:0]  exc;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int   n_chk;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour written from the requirements, one edge at a time.
  task automatic model_edge(input logic r, input logic st, input logic fl,
                            input logic [31:0] ins, input logic [31:0] p, input logic ds);
    logic bad;
    bad = (p[1:0] != 2'b00) || (p < 32'h0000_3000) || (p > 32'h0000_6FFC);
    if (r) begin
      m.instr = 32'h0; m.pcv = 32'h0000_3000; m.pc8 = 32'h0000_3008;
      m.vld = 1'b0; m.bd = 1'b0; m.exc = 5'd0; m.fcnt = 32'h0; m.scnt = 32'h0;
    end else if (fl) begin
      m.instr = 32'h0; m.pcv = p; m.pc8 = p + 32'd8;
      m.vld = 1'b0; m.bd = 1'b0; m.exc = 5'd0;
    end else if (st) begin
      if (m.scnt != 32'hFFFF_FFFF) m.scnt = m.scnt + 32'd1;
    end else begin
      m.instr = bad ? 32'h0 : ins;
      m.exc   = bad ? 5'd4 : 5'd0;
      m.pcv = p; m.pc8 = p + 32'd8; m.vld = 1'b1; m.bd = ds;
      if (m.fcnt != 32'hFFFF_FFFF) m.fcnt = m.fcnt + 32'd1;
    end
  endtask

  task automatic step(input logic r, input logic st, input logic fl,
                      input logic [31:0] ins, input logic [31:0] p, input logic ds);
    exp_t e;
    reset = r; Stall = st; Flush = fl; Instr = ins; pc = p; InDelaySlot = ds;
    model_edge(r, st, fl, ins, p, ds);
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("Instr_D",   Instr_D,          e.instr);
      chk("pc_D",      pc_D,             e.pcv);
      chk("pc8_D",     pc8_D,            e.pc8);
      chk("Valid_D",   32'(Valid_D),     32'(e.vld));
      chk("BD_D",      32'(BD_D),        32'(e.bd));
      chk("ExcCode_D", 32'(ExcCode_D),   32'(e.exc));
      chk("FetchCnt",  FetchCnt,         e.fcnt);
      chk("StallCnt",  StallCnt,         e.scnt);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; Stall = 1'b0; Flush = 1'b0; Instr = 32'h0; pc = 32'h0; InDelaySlot = 1'b0;
    m = '{instr: 32'h0, pcv: 32'h0, pc8: 32'h0, vld: 1'b0, bd: 1'b0, exc: 5'd0, fcnt: 32'h0, scnt: 32'h0};
    @(negedge clk);

    // Reset for two cycles, with hazard requests active to show reset wins.
    step(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_4000, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_4000, 1'b1);
    chk("rst_pc_D",  pc_D,  32'h0000_3000);
    chk("rst_pc8_D", pc8_D, 32'h0000_3008);
    chk("rst_cnts",  FetchCnt | StallCnt, 32'h0);

    // First load after reset.
    step(1'b0, 1'b0, 1'b0, 32'h3C01_1234, 32'h0000_3004, 1'b1);
    chk("ld_instr", Instr_D, 32'h3C01_1234);
    chk("ld_pc8",   pc8_D,   32'h0000_300C);
    chk("ld_fcnt",  FetchCnt, 32'd1);

    // Stall three cycles with changing inputs.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 32'h1111_0000 + 32'(i), 32'h0000_3100 + 32'(i * 4), i[0]);
    chk("stl_pc_frozen", pc_D, 32'h0000_3004);
    chk("stl_scnt",      StallCnt, 32'd3);
    chk("stl_fcnt",      FetchCnt, 32'd1);

    // Flush wins over Stall.
    step(1'b0, 1'b1, 1'b1, 32'h2222_2222, 32'h0000_3010, 1'b1);
    chk("fl_pc",   pc_D, 32'h0000_3010);
    chk("fl_scnt", StallCnt, 32'd3);

    // Fetch address boundaries.
    step(1'b0, 1'b0, 1'b0, 32'hAAAA_0001, 32'h0000_3002, 1'b0);
    chk("misalign_exc", 32'(ExcCode_D), 32'd4);
    step(1'b0, 1'b0, 1'b0, 32'hAAAA_0002, 32'h0000_7000, 1'b0);
    chk("hi_exc", 32'(ExcCode_D), 32'd4);
    step(1'b0, 1'b0, 1'b0, 32'hAAAA_0003, 32'hFFFF_FFFC, 1'b1);
    chk("wrap_pc8", pc8_D, 32'h0000_0004);
    step(1'b0, 1'b0, 1'b0, 32'hAAAA_0004, 32'h0000_2FFC, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'hAAAA_0005, 32'h0000_6FFC, 1'b0);
    chk("limit_ok", 32'(ExcCode_D), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'hAAAA_0006, 32'h0000_3000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'hAAAA_0007, 32'h0000_6FFD, 1'b0);

    // Mixed random traffic.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] rp;
      rp = 32'h0000_2F00 + ($urandom_range(0, 32'h4200) & 32'hFFFF_FFFD);
      step(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           $urandom, rp, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a stall, then resume.
    step(1'b0, 1'b1, 1'b0, 32'h5555_5555, 32'h0000_3200, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h5555_5555, 32'h0000_3200, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0123_4567, 32'h0000_3008, 1'b0);

    // Stall counter saturation from a preloaded value near the top.
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    m.scnt = 32'hFFFF_FFFE;
    chk("scnt_preload", StallCnt, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 32'h7777_0000 + 32'(i), 32'h0000_3300, 1'b0);
    chk("scnt_sat", StallCnt, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b0, 32'h7777_7777, 32'h0000_3300, 1'b1);
    chk("rst_mid_stall_scnt", StallCnt, 32'h0);
    chk("rst_mid_stall_pc",   pc_D,     32'h0000_3000);

    // Fetch counter saturation, faulted loads included.
    force dut.r_fetch_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_fetch_cnt;
    m.fcnt = 32'hFFFF_FFFE;
    step(1'b0, 1'b0, 1'b0, 32'h8888_0001, 32'h0000_3400, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h8888_0002, 32'h0000_3401, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h8888_0003, 32'h0000_3408, 1'b0);
    chk("fcnt_sat", FetchCnt, 32'hFFFF_FFFF);

    if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
